// File: rtl/min_search_unit.sv
// min_search_unit: streaming running-minimum search over LANES-wide beats with winner address and beat count.
// Optional MIN_SEARCH_THRESHOLD_EN adds threshold/early_hit to end a search early.
module min_search_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LANES  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    valid_in,
  input  logic                    last_in,
  input  logic [LANES-1:0]        lane_en,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] data_in,
`ifdef MIN_SEARCH_THRESHOLD_EN
  input  logic [DATA_W-1:0]       threshold,
  output logic                    early_hit,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [DATA_W-1:0]       min_value,
  output logic [ADDR_W-1:0]       min_addr,
  output logic [CNT_W-1:0]        beat_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] bmin;
  logic [ADDR_W-1:0] bidx;
  logic bany, acc, upd, hit;
  // strict < while scanning upward keeps the lowest lane on ties
  always_comb begin
    bmin = '1;
    bidx = '0;
    bany = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (lane_en[i] && (!bany || data_in[i*DATA_W +: DATA_W] < bmin)) begin
        bmin = data_in[i*DATA_W +: DATA_W];
        bidx = ADDR_W'(i);
        bany = 1'b1;
      end
  end
  assign acc = state == ACCUM && valid_in && !start;
  assign upd = acc && bany && (!found || bmin < min_value);
`ifdef MIN_SEARCH_THRESHOLD_EN
  assign hit = upd && bmin <= threshold;
`else
  assign hit = 1'b0;
`endif
  assign busy = state == ACCUM;
  assign done = state == DONE;
  always_comb state_nx = start ? ACCUM : (acc && (last_in || hit)) ? DONE : state == DONE ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || start) begin
      found      <= 1'b0;
      min_value  <= '1;
      min_addr   <= '0;
      beat_count <= '0;
    end else if (acc) begin
      beat_count <= &beat_count ? beat_count : beat_count + 1'b1;
      if (upd) begin
        found     <= 1'b1;
        min_value <= bmin;
        min_addr  <= base_addr + bidx;
      end
    end
`ifdef MIN_SEARCH_THRESHOLD_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) early_hit <= 1'b0;
    else if (start) early_hit <= 1'b0;
    else if (hit) early_hit <= 1'b1;
`endif
endmodule

// File: tb/tb_min_search_unit.sv
// tb_min_search_unit: randomized and directed stimulus with a queue scoreboard checked on each done pulse.
module tb_min_search_unit;
  localparam int L = 8, DW = 32, AW = 32, CW = 16;
  typedef struct packed {
    logic [L-1:0]    en;
    logic [AW-1:0]   base;
    logic [L*DW-1:0] data;
  } beat_t;
  typedef struct {
    logic [DW-1:0] mv;
    logic [AW-1:0] ma;
    logic          found;
    int            cnt;
    int            cyc;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, valid_in = 0, last_in = 0;
  logic [L-1:0] lane_en = '0;
  logic [AW-1:0] base_addr = '0;
  logic [L*DW-1:0] data_in = '0;
  logic busy, done, found;
  logic [DW-1:0] min_value;
  logic [AW-1:0] min_addr;
  logic [CW-1:0] beat_count;
`ifdef MIN_SEARCH_THRESHOLD_EN
  logic [DW-1:0] threshold = '0;
  logic early_hit;
`endif
  int total = 0, bad = 0, cyc = 0;
  beat_t bq[$];
  exp_t expq[$];
  beat_t b;

  min_search_unit #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in), .last_in(last_in),
    .lane_en(lane_en), .base_addr(base_addr), .data_in(data_in),
`ifdef MIN_SEARCH_THRESHOLD_EN
    .threshold(threshold), .early_hit(early_hit),
`endif
    .busy(busy), .done(done), .found(found), .min_value(min_value),
    .min_addr(min_addr), .beat_count(beat_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] w);
    total++;
    if (a !== w) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", n, a, w, cyc);
    end
  endtask

  // global minimum over every enabled value, then its first occurrence in stream order
  function automatic exp_t model();
    exp_t e;
    logic [DW-1:0] m = '1;
    bit hit = 0;
    e.found = 0;
    e.ma = '0;
    foreach (bq[k])
      for (int i = 0; i < L; i++)
        if (bq[k].en[i]) begin
          e.found = 1;
          if (bq[k].data[i*DW +: DW] < m) m = bq[k].data[i*DW +: DW];
        end
    foreach (bq[k])
      for (int i = 0; i < L; i++)
        if (e.found && !hit && bq[k].en[i] && bq[k].data[i*DW +: DW] == m) begin
          e.ma = bq[k].base + AW'(i);
          hit = 1;
        end
    e.mv = m;
    e.cnt = bq.size();
    e.cyc = cyc + 1;
    return e;
  endfunction

  function automatic logic [L*DW-1:0] mk(input logic [DW-1:0] fill, input int lane, input logic [DW-1:0] v);
    logic [L*DW-1:0] r;
    for (int i = 0; i < L; i++) r[i*DW +: DW] = (i == lane) ? v : fill;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=1 want=0 at cycle %0d", cyc);
      end else begin
        e = expq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("min_value", 64'(min_value), 64'(e.mv));
        chk("min_addr", 64'(min_addr), 64'(e.ma));
        chk("found", 64'(found), 64'(e.found));
        chk("beat_count", 64'(beat_count), 64'(e.cnt));
        chk("busy_in_done", 64'(busy), 64'd0);
      end
    end else if (expq.size() != 0 && cyc >= expq[0].cyc) begin
      e = expq.pop_front();
      total++;
      bad++;
      $display("FAIL done_missing got=0 want=1 at cycle %0d", e.cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic send(input beat_t x, input bit last, input bit push);
    lane_en = x.en;
    base_addr = x.base;
    data_in = x.data;
    last_in = last;
    valid_in = 1;
    if (push) expq.push_back(model());
    tick();
    valid_in = 0;
    last_in = 0;
  endtask

  task automatic search();
    do_start();
    foreach (bq[k]) begin
      send(bq[k], k == bq.size() - 1, k == bq.size() - 1);
      if (k != bq.size() - 1) repeat ($urandom_range(0, 1)) tick();
    end
    tick();
    tick();
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_busy"}, 64'(busy), 64'd0);
    chk({n, "_done"}, 64'(done), 64'd0);
    chk({n, "_found"}, 64'(found), 64'd0);
    chk({n, "_min_value"}, 64'(min_value), 64'(32'hFFFF_FFFF));
    chk({n, "_min_addr"}, 64'(min_addr), 64'd0);
    chk({n, "_beat_count"}, 64'(beat_count), 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1;
    tick();
    // valid_in while idle is ignored
    b = '{en: 8'hFF, base: 32'd7, data: mk(32'd3, -1, 32'd0)};
    send(b, 0, 0);
    chk("idle_beat_count", 64'(beat_count), 64'd0);
    chk("idle_found", 64'(found), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    // lowest-index tie inside one beat
    bq.delete();
    bq.push_back('{en: 8'hFF, base: 32'd100,
      data: {32'd4, 32'd6, 32'd5, 32'd3, 32'd8, 32'd3, 32'd7, 32'd9}});
    do_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    send(bq[0], 1, 1);
    tick();
    tick();
    // earliest-beat tie across beats
    bq.delete();
    bq.push_back('{en: 8'hFF, base: 32'd0, data: mk(32'd100, 5, 32'd50)});
    bq.push_back('{en: 8'hFF, base: 32'd8, data: mk(32'd100, 5, 32'd20)});
    bq.push_back('{en: 8'hFF, base: 32'd16, data: mk(32'd100, 5, 32'd20)});
    search();
    // lane masking and an all-disabled beat
    bq.delete();
    b = '{en: 8'hFE, base: 32'd40, data: mk(32'd50, 3, 32'd2)};
    b.data[DW-1:0] = 32'd1;
    bq.push_back(b);
    bq.push_back('{en: 8'h00, base: 32'd0, data: mk(32'd1, -1, 32'd0)});
    search();
    // address wrap
    bq.delete();
    bq.push_back('{en: 8'hFF, base: 32'hFFFF_FFFE, data: mk(32'd100, 3, 32'd5)});
    search();
    // a lone all-ones value still wins
    bq.delete();
    bq.push_back('{en: 8'h10, base: 32'd200, data: mk(32'hFFFF_FFFF, -1, 32'd0)});
    search();
    // start together with a beat discards the beat
    start = 1;
    valid_in = 1;
    last_in = 1;
    lane_en = 8'hFF;
    data_in = mk(32'd100, 0, 32'd1);
    tick();
    start = 0;
    valid_in = 0;
    last_in = 0;
    chk("start_beat_count", 64'(beat_count), 64'd0);
    chk("start_beat_found", 64'(found), 64'd0);
    chk("start_beat_done", 64'(done), 64'd0);
    bq.delete();
    bq.push_back('{en: 8'hFF, base: 32'd60, data: mk(32'd30, 6, 32'd4)});
    send(bq[0], 1, 1);
    tick();
    tick();
    // start mid-search clears the count
    bq.delete();
    bq.push_back('{en: 8'hFF, base: 32'd0, data: mk(32'd9, 2, 32'd1)});
    do_start();
    send(bq[0], 0, 0);
    send(bq[0], 0, 0);
    chk("mid_count", 64'(beat_count), 64'd2);
    do_start();
    chk("restart_count", 64'(beat_count), 64'd0);
    chk("restart_min", 64'(min_value), 64'(32'hFFFF_FFFF));
    bq.delete();
    bq.push_back('{en: 8'hFF, base: 32'd80, data: mk(32'd9, 1, 32'd8)});
    send(bq[0], 1, 1);
    tick();
    tick();
    // asynchronous reset mid-search
    do_start();
    send(bq[0], 0, 0);
    #3 rst_n = 0;
    #1 chk_reset_vals("async_rst");
    tick();
    rst_n = 1;
    tick();
    send(bq[0], 0, 0);
    chk("post_rst_idle_count", 64'(beat_count), 64'd0);
`ifdef MIN_SEARCH_THRESHOLD_EN
    threshold = 32'd10;
    bq.delete();
    bq.push_back('{en: 8'hFF, base: 32'd0, data: mk(32'd100, 2, 32'd12)});
    bq.push_back('{en: 8'hFF, base: 32'd0, data: mk(32'd100, 6, 32'd9)});
    do_start();
    send(bq[0], 0, 0);
    send(bq[1], 0, 1);
    chk("early_hit", 64'(early_hit), 64'd1);
    send('{en: 8'hFF, base: 32'd0, data: mk(32'd100, 1, 32'd2)}, 0, 0);
    chk("early_hold_min", 64'(min_value), 64'd9);
    chk("early_hold_flag", 64'(early_hit), 64'd1);
    threshold = '0;
    tick();
`endif
    // randomized searches; accepted values stay >= 1
    repeat (40) begin
      bq.delete();
      repeat ($urandom_range(1, 4)) begin
        b.en = ($urandom_range(0, 5) == 0) ? '0 : L'($urandom);
        b.base = $urandom;
        for (int i = 0; i < L; i++)
          b.data[i*DW +: DW] = ($urandom_range(0, 9) == 0) ? '1 : DW'($urandom_range(1, 12));
        bq.push_back(b);
      end
      search();
    end
    repeat (5) tick();
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_done got=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
